// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback sequencer: FSM state
// encodings and the load funct3 codes it understands.
package writeback_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        STROBE  = 2'd2,
        GAP     = 2'd3
    } wb_state_e;

    localparam logic [2:0] WB_LB  = 3'b000;
    localparam logic [2:0] WB_LH  = 3'b001;
    localparam logic [2:0] WB_LW  = 3'b010;
    localparam logic [2:0] WB_LBU = 3'b100;
    localparam logic [2:0] WB_LHU = 3'b101;

endpackage

// File: rtl/writeback_load_extend.sv
// Load lane select plus sign/zero extension for the writeback stage.
// Half lane uses addr[1] only; unknown funct3 yields 0 and bad_funct3.
module writeback_load_extend
    import writeback_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        bad_funct3
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte and half out of the aligned word
    always_comb begin
        case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane according to the load type
    always_comb begin
        data       = 32'd0;
        bad_funct3 = 1'b0;
        case (funct3)
            WB_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            WB_LH:   data = {{16{half_lane[15]}}, half_lane};
            WB_LW:   data = rdata;
            WB_LBU:  data = {24'd0, byte_lane};
            WB_LHU:  data = {16'd0, half_lane};
            default: bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Writeback sequencer: ALU results and load responses to the regfile
// write port with a one-cycle strobe and a one-cycle low gap.
// Optional macro WB_FWD_EN adds the in-flight write bypass outputs.
module writeback
    import writeback_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_ready_o,
    input  logic        ld_req_i,
    input  logic [4:0]  ld_rd_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_i,
    output logic        ld_ready_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] wd_o,
    output logic [4:0]  wd_rd_o,
    output logic        wd_q_o,
    output logic        busy_o,
`ifdef WB_FWD_EN
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_rd_o,
    output logic [31:0] fwd_data_o,
`endif
    output logic        err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    wb_state_e     state, state_n;
    logic [CW-1:0] cnt;
    logic [4:0]    ld_rd;
    logic [2:0]    ld_f3;
    logic [1:0]    ld_addr;
    logic [31:0]   ext_data;
    logic          bad_f3;
    logic          alu_take;
    logic          ld_take;
    logic          ld_done;
    logic          timed_out;

    writeback_load_extend u_ext (
        .funct3     (ld_f3),
        .addr       (ld_addr),
        .rdata      (mem_rdata_i),
        .data       (ext_data),
        .bad_funct3 (bad_f3)
    );

    assign ld_ready_o  = (state == IDLE) && !reset;
    assign alu_ready_o = (state == IDLE) && !reset && !ld_req_i;
    assign ld_take     = ld_ready_o && ld_req_i;
    assign alu_take    = alu_ready_o && alu_valid_i;
    assign ld_done     = (state == LD_WAIT) && mem_rvalid_i;
    assign timed_out   = (state == LD_WAIT) && !mem_rvalid_i
                         && (cnt == LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic; a load request wins over an ALU result
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (ld_req_i)
                    state_n = LD_WAIT;
                else if (alu_valid_i && alu_rd_i != 5'd0)
                    state_n = STROBE;
            end
            LD_WAIT: begin
                if (mem_rvalid_i)
                    state_n = (ld_rd != 5'd0) ? STROBE : IDLE;
                else if (cnt == LAST)
                    state_n = IDLE;
            end
            STROBE:  state_n = GAP;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs, load context and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_o    <= 32'd0;
            wd_rd_o <= 5'd0;
            wd_q_o  <= 1'b0;
            busy_o  <= 1'b0;
            err_o   <= 1'b0;
            cnt     <= '0;
            ld_rd   <= 5'd0;
            ld_f3   <= 3'd0;
            ld_addr <= 2'd0;
        end else begin
            wd_q_o <= (state_n == STROBE);
            busy_o <= (state_n != IDLE);
            if (ld_take) begin
                ld_rd   <= ld_rd_i;
                ld_f3   <= ld_funct3_i;
                ld_addr <= ld_addr_i;
                cnt     <= '0;
            end else if (state == LD_WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (alu_take && alu_rd_i != 5'd0) begin
                wd_o    <= alu_data_i;
                wd_rd_o <= alu_rd_i;
            end
            if (ld_done && ld_rd != 5'd0) begin
                wd_o    <= ext_data;
                wd_rd_o <= ld_rd;
            end
            if ((ld_done && bad_f3) || timed_out)
                err_o <= 1'b1;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid_o = (state == STROBE) || (state == GAP);
    assign fwd_rd_o    = wd_rd_o;
    assign fwd_data_o  = wd_o;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for the writeback sequencer
// (TIMEOUT overridden to 4 to exercise the abandon path).
module tb_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        alu_ready;
    logic        ld_req = 1'b0;
    logic [4:0]  ld_rd = 5'd0;
    logic [2:0]  ld_f3 = 3'd0;
    logic [1:0]  ld_addr = 2'd0;
    logic        ld_ready;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [31:0] wd;
    logic [4:0]  wd_rd;
    logic        wd_q;
    logic        busy;
    logic        err;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int tests = 0;
    int fails = 0;

    writeback #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid_i  (alu_valid),
        .alu_rd_i     (alu_rd),
        .alu_data_i   (alu_data),
        .alu_ready_o  (alu_ready),
        .ld_req_i     (ld_req),
        .ld_rd_i      (ld_rd),
        .ld_funct3_i  (ld_f3),
        .ld_addr_i    (ld_addr),
        .ld_ready_o   (ld_ready),
        .mem_rvalid_i (rvalid),
        .mem_rdata_i  (rdata),
        .wd_o         (wd),
        .wd_rd_o      (wd_rd),
        .wd_q_o       (wd_q),
        .busy_o       (busy),
`ifdef WB_FWD_EN
        .fwd_valid_o  (fwd_valid),
        .fwd_rd_o     (fwd_rd),
        .fwd_data_o   (fwd_data),
`endif
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++; if (wd !== 32'd0) begin fails++; $display("FAIL rst_wd got %h want 0", wd); end
        tests++; if (wd_rd !== 5'd0) begin fails++; $display("FAIL rst_wd_rd got %0d want 0", wd_rd); end
        tests++; if (wd_q !== 1'b0) begin fails++; $display("FAIL rst_wd_q got %b want 0", wd_q); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", err); end
        tests++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL rst_alu_ready got %b want 0", alu_ready); end
        tests++; if (ld_ready !== 1'b0) begin fails++; $display("FAIL rst_ld_ready got %b want 0", ld_ready); end
        reset = 1'b0;
        #1;
        tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ld_ready got %b want 1", ld_ready); end
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL post_rst_alu_ready got %b want 1", alu_ready); end
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        #1;
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL alu_accept got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        #1;
        tests++; if (wd_q !== 1'b1) begin fails++; $display("FAIL alu_strobe got %b want 1", wd_q); end
        tests++; if (wd_rd !== 5'd5) begin fails++; $display("FAIL alu_rd got %0d want 5", wd_rd); end
        tests++; if (wd !== 32'h1234) begin fails++; $display("FAIL alu_data got %h want 00001234", wd); end
        tests++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL alu_ready_strobe got %b want 0", alu_ready); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL alu_busy got %b want 1", busy); end
        tick();
        tests++; if (wd_q !== 1'b0) begin fails++; $display("FAIL alu_gap got %b want 0", wd_q); end
        tests++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL alu_ready_gap got %b want 0", alu_ready); end
        tests++; if (wd !== 32'h1234) begin fails++; $display("FAIL alu_hold got %h want 00001234", wd); end
        tick();
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL alu_ready_n3 got %b want 1", alu_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL alu_idle got %b want 0", busy); end
    endtask

    task automatic test_x0_discard();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        #1;
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL x0_accept got %b want 1", alu_ready); end
        tick();
        alu_rd = 5'd7; alu_data = 32'h55;
        #1;
        tests++; if (wd_q !== 1'b0) begin fails++; $display("FAIL x0_no_strobe got %b want 0", wd_q); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL x0_busy got %b want 0", busy); end
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL x0_next_ready got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        #1;
        tests++; if (wd_q !== 1'b1) begin fails++; $display("FAIL x0_next_strobe got %b want 1", wd_q); end
        tests++; if (wd_rd !== 5'd7) begin fails++; $display("FAIL x0_next_rd got %0d want 7", wd_rd); end
        tests++; if (wd !== 32'h55) begin fails++; $display("FAIL x0_next_data got %h want 00000055", wd); end
        tick();
        tick();
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3 [7];
        logic [1:0]  ad [7];
        logic [31:0] ex [7];
        f3[0] = 3'b000; ad[0] = 2'd3; ex[0] = 32'hFFFFFF80;
        f3[1] = 3'b100; ad[1] = 2'd3; ex[1] = 32'h00000080;
        f3[2] = 3'b001; ad[2] = 2'd2; ex[2] = 32'hFFFF80FF;
        f3[3] = 3'b101; ad[3] = 2'd0; ex[3] = 32'h00007F01;
        f3[4] = 3'b010; ad[4] = 2'd0; ex[4] = 32'h80FF7F01;
        f3[5] = 3'b000; ad[5] = 2'd1; ex[5] = 32'h0000007F;
        f3[6] = 3'b001; ad[6] = 2'd3; ex[6] = 32'hFFFF80FF;
        for (int i = 0; i < 7; i++) begin
            ld_req = 1'b1; ld_rd = 5'(10 + i); ld_f3 = f3[i]; ld_addr = ad[i];
            #1;
            tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL ld%0d_ready got %b want 1", i, ld_ready); end
            tick();
            ld_req = 1'b0; ld_f3 = 3'd0; ld_addr = 2'd0;
            tick();
            tests++; if (busy !== 1'b1 || wd_q !== 1'b0) begin fails++; $display("FAIL ld%0d_wait got busy=%b q=%b want busy=1 q=0", i, busy, wd_q); end
            rvalid = 1'b1; rdata = 32'h80FF7F01;
            tick();
            rvalid = 1'b0;
            #1;
            tests++; if (wd_q !== 1'b1) begin fails++; $display("FAIL ld%0d_strobe got %b want 1", i, wd_q); end
            tests++; if (wd !== ex[i]) begin fails++; $display("FAIL ld%0d_data got %h want %h", i, wd, ex[i]); end
            tests++; if (wd_rd !== 5'(10 + i)) begin fails++; $display("FAIL ld%0d_rd got %0d want %0d", i, wd_rd, 10 + i); end
            tick();
            tick();
        end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL ld_err got %b want 0", err); end
    endtask

    task automatic test_timeout_edge();
        ld_req = 1'b1; ld_rd = 5'd20; ld_f3 = 3'b010;
        tick();
        ld_req = 1'b0;
        tick(); tick(); tick();
        rvalid = 1'b1; rdata = 32'hCAFE0001;
        tick();
        rvalid = 1'b0;
        #1;
        tests++; if (wd_q !== 1'b1) begin fails++; $display("FAIL to_edge_strobe got %b want 1", wd_q); end
        tests++; if (wd !== 32'hCAFE0001) begin fails++; $display("FAIL to_edge_data got %h want cafe0001", wd); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL to_edge_err got %b want 0", err); end
        tick();
        tick();
    endtask

    task automatic test_timeout();
        ld_req = 1'b1; ld_rd = 5'd21; ld_f3 = 3'b010;
        tick();
        ld_req = 1'b0;
        for (int c = 1; c < 4; c++) begin
            tick();
            tests++; if (wd_q !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL to_wait%0d got q=%b err=%b busy=%b want 0 0 1", c, wd_q, err, busy); end
        end
        tick();
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_err got %b want 1", err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL to_idle got %b want 0", busy); end
        tests++; if (wd_q !== 1'b0) begin fails++; $display("FAIL to_nostrobe got %b want 0", wd_q); end
        rvalid = 1'b1; rdata = 32'hDEADBEEF;
        tick();
        rvalid = 1'b0;
        #1;
        tests++; if (wd_q !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL to_late_rvalid got q=%b busy=%b want 0 0", wd_q, busy); end
        tests++; if (wd !== 32'hCAFE0001) begin fails++; $display("FAIL to_wd_kept got %h want cafe0001", wd); end
    endtask

    task automatic test_collision_reset();
        ld_req = 1'b1; ld_rd = 5'd4; ld_f3 = 3'b010;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h77;
        #1;
        tests++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL col_alu_ready got %b want 0", alu_ready); end
        tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL col_ld_ready got %b want 1", ld_ready); end
        tick();
        ld_req = 1'b0; alu_valid = 1'b0;
        #1;
        tests++; if (busy !== 1'b1 || wd_q !== 1'b0) begin fails++; $display("FAIL col_tracked got busy=%b q=%b want 1 0", busy, wd_q); end
        reset = 1'b1;
        #1;
        tests++; if (busy !== 1'b0 || wd_q !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL mid_rst got busy=%b q=%b err=%b want 0 0 0", busy, wd_q, err); end
        tests++; if (wd !== 32'd0 || wd_rd !== 5'd0) begin fails++; $display("FAIL mid_rst_wd got %h/%0d want 0/0", wd, wd_rd); end
        tests++; if (ld_ready !== 1'b0 || alu_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready got %b%b want 00", ld_ready, alu_ready); end
        tick();
        reset = 1'b0;
        rvalid = 1'b1; rdata = 32'h12345678;
        tick();
        rvalid = 1'b0;
        #1;
        tests++; if (wd_q !== 1'b0 || busy !== 1'b0 || wd !== 32'd0) begin fails++; $display("FAIL post_rst_rvalid got q=%b busy=%b wd=%h want 0 0 0", wd_q, busy, wd); end
    endtask

    task automatic test_bad_funct3();
        ld_req = 1'b1; ld_rd = 5'd9; ld_f3 = 3'b011; ld_addr = 2'd0;
        tick();
        ld_req = 1'b0;
        rvalid = 1'b1; rdata = 32'hFFFFFFFF;
        tick();
        rvalid = 1'b0;
        #1;
        tests++; if (wd_q !== 1'b1) begin fails++; $display("FAIL bad_f3_strobe got %b want 1", wd_q); end
        tests++; if (wd !== 32'd0) begin fails++; $display("FAIL bad_f3_data got %h want 0", wd); end
        tests++; if (wd_rd !== 5'd9) begin fails++; $display("FAIL bad_f3_rd got %0d want 9", wd_rd); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL bad_f3_err got %b want 1", err); end
        tick();
        tick();
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", err); end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_x0_discard();
        test_load_extend();
        test_timeout_edge();
        test_timeout();
        test_collision_reset();
        test_bad_funct3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
